// File: rtl/seg_scan8_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan8_ctrl_if
//  Description : Bundle of shadow-write, commit and scan-output signals
//                for the 8-digit 7-segment scan controller.
//                master : upstream writer / observer (drives WE, WADDR,
//                         WDATA, COMMIT; reads PEND, SEL, SEG, DIG_EN, FRAME)
//                slave  : the scan controller itself
//  Revision    : 1.0  initial release
// ============================================================================
interface seg_scan8_ctrl_if;
  logic       WE;      // shadow-bank write strobe
  logic [2:0] WADDR;   // shadow digit index, 0 = least significant
  logic [3:0] WDATA;   // digit value
  logic       COMMIT;  // request shadow->active copy at next frame boundary
  logic       PEND;    // commit waiting for the frame boundary
  logic [2:0] SEL;     // digit select
  logic [6:0] SEG;     // segments {a,b,c,d,e,f,g}, active-high
  logic       DIG_EN;  // digit enable (high in SHOW)
  logic       FRAME;   // one-cycle pulse on the 7->0 select wrap

  modport master (
    output WE, WADDR, WDATA, COMMIT,
    input  PEND, SEL, SEG, DIG_EN, FRAME
  );

  modport slave (
    input  WE, WADDR, WDATA, COMMIT,
    output PEND, SEL, SEG, DIG_EN, FRAME
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan8_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan8_ctrl
//  Description : Multiplexed 8-digit 7-segment scan controller with a
//                double-buffered digit bank and dead-time blanking.
//                Each digit is scanned as BLANK (BLANK_CYC cycles, dark)
//                followed by SHOW (DIV cycles, lit). The shadow bank is
//                copied into the active bank on the frame boundary (the
//                SHOW->BLANK edge where SEL wraps 7->0) if a commit is
//                pending.
//  Ports       : CP      - clock, rising edge
//                CR      - asynchronous active-high reset
//                bus     - seg_scan8_ctrl_if.slave (write/commit in,
//                          PEND/SEL/SEG/DIG_EN/FRAME out, all registered)
//  Options     : SEG_SCAN8_LZ_BLANK_EN - leading-zero suppression
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan8_ctrl #(
  parameter int DIV       = 65536,  // SHOW length per digit (>=2)
  parameter int BLANK_CYC = 16      // BLANK length per digit (>=1)
) (
  input  logic                  CP,
  input  logic                  CR,
  seg_scan8_ctrl_if.slave       bus
);

  localparam int c_tmax = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int c_tw   = $clog2(c_tmax);
  localparam logic [c_tw-1:0] c_div_last   = c_tw'(DIV - 1);
  localparam logic [c_tw-1:0] c_blank_last = c_tw'(BLANK_CYC - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t          state_q,  state_d;
  logic [c_tw-1:0] timer_q,  timer_d;
  logic [2:0]      sel_q,    sel_d;
  logic [6:0]      seg_q,    seg_d;
  logic            dig_en_q, dig_en_d;
  logic            frame_q,  frame_d;
  logic            pend_q,   pend_d;
  logic [7:0][3:0] shadow_q, shadow_d;
  logic [7:0][3:0] active_q, active_d;
  logic            w_boundary;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1111110;
      4'd1:    seg_decode = 7'b0110000;
      4'd2:    seg_decode = 7'b1101101;
      4'd3:    seg_decode = 7'b1111001;
      4'd4:    seg_decode = 7'b0110011;
      4'd5:    seg_decode = 7'b1011011;
      4'd6:    seg_decode = 7'b1011111;
      4'd7:    seg_decode = 7'b1110000;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1111011;
      default: seg_decode = 7'b1100011;
    endcase
  endfunction

`ifdef SEG_SCAN8_LZ_BLANK_EN
  // Digit k>0 is dark when it and every higher digit are zero. Derived from
  // the active bank only, so it can only change on a commit.
  logic [7:0] w_lz_mask;
  always_comb begin
    logic zero_above;
    w_lz_mask  = 8'b0;
    zero_above = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      zero_above   = zero_above & (active_q[k] == 4'd0);
      w_lz_mask[k] = zero_above;
    end
  end
`endif

  // Scan sequencer plus bank/commit bookkeeping.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 1'b1;
    sel_d      = sel_q;
    w_boundary = 1'b0;

    case (state_q)
      ST_BLANK: begin
        if (timer_q == c_blank_last) begin
          state_d = ST_SHOW;
          timer_d = '0;
        end
      end
      default: begin
        if (timer_q == c_div_last) begin
          state_d    = ST_BLANK;
          timer_d    = '0;
          sel_d      = sel_q + 3'd1;
          w_boundary = (sel_q == 3'd7);
        end
      end
    endcase

    frame_d = w_boundary;

    // A COMMIT arriving on the boundary itself re-arms PEND for the next
    // frame rather than being consumed by the copy happening now.
    pend_d   = bus.COMMIT ? 1'b1 : (w_boundary ? 1'b0 : pend_q);

    // Copy uses the pre-write shadow; a same-cycle write lands in shadow only.
    active_d = (w_boundary && pend_q) ? shadow_q : active_q;
    shadow_d = shadow_q;
    if (bus.WE) begin
      shadow_d[bus.WADDR] = bus.WDATA;
    end

    // Outputs are registered from next-state so SEG/DIG_EN/SEL move together.
    // active_q only changes on a SHOW->BLANK edge, where SEG goes dark anyway.
    dig_en_d = (state_d == ST_SHOW);
    seg_d    = 7'b0;
    if (state_d == ST_SHOW) begin
`ifdef SEG_SCAN8_LZ_BLANK_EN
      if (!w_lz_mask[sel_d]) begin
        seg_d = seg_decode(active_q[sel_d]);
      end
`else
      seg_d = seg_decode(active_q[sel_d]);
`endif
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state_q  <= ST_BLANK;
      timer_q  <= '0;
      sel_q    <= 3'd0;
      seg_q    <= 7'b0;
      dig_en_q <= 1'b0;
      frame_q  <= 1'b0;
      pend_q   <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d;
      dig_en_q <= dig_en_d;
      frame_q  <= frame_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign bus.PEND   = pend_q;
  assign bus.SEL    = sel_q;
  assign bus.SEG    = seg_q;
  assign bus.DIG_EN = dig_en_q;
  assign bus.FRAME  = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan8_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan8_ctrl
//  Description : Self-checking bench for seg_scan8_ctrl. The reference model
//                tracks the number of clock edges since reset release and
//                derives the scan position arithmetically; digit banks and
//                the commit flag are kept as plain arrays.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan8_ctrl;

  localparam int DIV       = 4;
  localparam int BLANK_CYC = 2;
  localparam int PER       = DIV + BLANK_CYC;
  localparam int FRAME_LEN = 8 * PER;

  logic CP = 1'b0;
  logic CR;
  always #5 CP = ~CP;

  seg_scan8_ctrl_if bus ();

  seg_scan8_ctrl #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .CP  (CP),
    .CR  (CR),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int         n;            // clock edges since reset release
  logic [3:0] m_shadow [8];
  logic [3:0] m_active [8];
  logic       m_pend;
  logic [6:0] c_tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1100011, 7'b1100011,
                             7'b1100011, 7'b1100011, 7'b1100011, 7'b1100011};

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n      = 0;
    m_pend = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = 4'd0;
      m_active[i] = 4'd0;
    end
  endtask

  function automatic logic [6:0] exp_seg();
    int  sel;
    bit  blank_lz;
    sel = (n / PER) % 8;
    if ((n % PER) < BLANK_CYC) return 7'b0;
    blank_lz = 1'b0;
`ifdef SEG_SCAN8_LZ_BLANK_EN
    if (sel > 0) begin
      blank_lz = 1'b1;
      for (int j = sel; j < 8; j++)
        if (m_active[j] != 4'd0) blank_lz = 1'b0;
    end
`endif
    return blank_lz ? 7'b0 : c_tbl[m_active[sel]];
  endfunction

  task automatic check_all();
    chk("sel",    7'(bus.SEL),    7'((n / PER) % 8));
    chk("dig_en", 7'(bus.DIG_EN), 7'((n % PER) >= BLANK_CYC));
    chk("frame",  7'(bus.FRAME),  7'(n > 0 && (n % FRAME_LEN) == 0));
    chk("pend",   7'(bus.PEND),   7'(m_pend));
    chk("seg",    bus.SEG,        exp_seg());
  endtask

  // One clock: drive inputs, advance the model on the edge, check at negedge.
  task automatic cyc(input logic we, input logic [2:0] a, input logic [3:0] d,
                     input logic c);
    bit boundary;
    bus.WE     = we;
    bus.WADDR  = a;
    bus.WDATA  = d;
    bus.COMMIT = c;
    @(posedge CP);
    boundary = ((n + 1) % FRAME_LEN) == 0;
    if (boundary && m_pend)
      for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
    if (we) m_shadow[a] = d;
    m_pend = c ? 1'b1 : (boundary ? 1'b0 : m_pend);
    n++;
    @(negedge CP);
    check_all();
    bus.WE     = 1'b0;
    bus.COMMIT = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 3'd0, 4'd0, 1'b0);
  endtask

  // Stop just before the boundary edge: the next cyc() call is the boundary.
  task automatic to_boundary();
    while (((n + 1) % FRAME_LEN) != 0) cyc(1'b0, 3'd0, 4'd0, 1'b0);
  endtask

  // Advance to the first SHOW cycle of the given digit.
  task automatic goto_show(input int dig);
    do cyc(1'b0, 3'd0, 4'd0, 1'b0);
    while (!((n % PER) == BLANK_CYC && ((n / PER) % 8) == dig));
  endtask

  initial begin
    CR         = 1'b1;
    bus.WE     = 1'b0;
    bus.WADDR  = 3'd0;
    bus.WDATA  = 4'd0;
    bus.COMMIT = 1'b0;
    model_reset();
    repeat (3) @(posedge CP);
    @(negedge CP);
    check_all();
    CR = 1'b0;

    // Idle scan from reset: covers first SHOW latency and one FRAME pulse.
    idle(60);

    // Write 1..8 into shadow, commit mid-frame.
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 4'(i + 1), 1'b0);
    cyc(1'b0, 3'd0, 4'd0, 1'b1);
    chk("pend_after_commit", 7'(bus.PEND), 7'd1);
    goto_show(7);
    chk("d7_before_wrap", bus.SEG, 7'b1111110);
    to_boundary();
    cyc(1'b0, 3'd0, 4'd0, 1'b0);
    chk("pend_cleared", 7'(bus.PEND), 7'd0);
    chk("frame_at_wrap", 7'(bus.FRAME), 7'd1);
    goto_show(0);
    chk("d0_after_commit", bus.SEG, 7'b0110000);
    goto_show(7);
    chk("d7_after_commit", bus.SEG, 7'b1111111);

    // Write on the boundary cycle while a commit applies.
    cyc(1'b0, 3'd0, 4'd0, 1'b1);
    to_boundary();
    cyc(1'b1, 3'd0, 4'd9, 1'b0);
    goto_show(0);
    chk("d0_old_shadow", bus.SEG, 7'b0110000);
    cyc(1'b0, 3'd0, 4'd0, 1'b1);
    to_boundary();
    cyc(1'b0, 3'd0, 4'd0, 1'b0);
    goto_show(0);
    chk("d0_nine", bus.SEG, 7'b1111011);

    // Hex value decodes to the fallback pattern.
    cyc(1'b1, 3'd3, 4'd12, 1'b0);
    cyc(1'b0, 3'd0, 4'd0, 1'b1);
    to_boundary();
    cyc(1'b0, 3'd0, 4'd0, 1'b0);
    goto_show(3);
    chk("d3_twelve", bus.SEG, 7'b1100011);

    // Commit raised exactly on a boundary with nothing pending.
    to_boundary();
    cyc(1'b1, 3'd1, 4'd6, 1'b1);
    chk("pend_boundary_commit", 7'(bus.PEND), 7'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(0, 3) == 0), 3'($urandom), 4'($urandom),
          ($urandom_range(0, 15) == 0));

    // Asynchronous reset during SHOW of digit 5 with a commit pending.
    goto_show(0);
    cyc(1'b1, 3'd5, 4'd7, 1'b1);
    goto_show(5);
    chk("pend_before_reset", 7'(bus.PEND), 7'd1);
    #2;
    CR = 1'b1;
    #1;
    chk("rst_sel",    7'(bus.SEL),    7'd0);
    chk("rst_seg",    bus.SEG,        7'd0);
    chk("rst_dig_en", 7'(bus.DIG_EN), 7'd0);
    chk("rst_pend",   7'(bus.PEND),   7'd0);
    chk("rst_frame",  7'(bus.FRAME),  7'd0);
    model_reset();
    @(negedge CP);
    CR = 1'b0;
    idle(FRAME_LEN + 10);
    goto_show(5);
    chk("d5_after_reset", bus.SEG, 7'b1111110);

    // Active = {0,0,0,0,0,4,0,7} (digit 7..0).
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 3'(i), (i == 0) ? 4'd7 : ((i == 2) ? 4'd4 : 4'd0), 1'b0);
    cyc(1'b0, 3'd0, 4'd0, 1'b1);
    to_boundary();
    cyc(1'b0, 3'd0, 4'd0, 1'b0);
    goto_show(0);
    chk("lz_d0", bus.SEG, 7'b1110000);
    goto_show(1);
    chk("lz_d1", bus.SEG, 7'b1111110);
    goto_show(2);
    chk("lz_d2", bus.SEG, 7'b0110011);
    goto_show(5);
    chk("lz_d5_dig_en", 7'(bus.DIG_EN), 7'd1);
`ifdef SEG_SCAN8_LZ_BLANK_EN
    chk("lz_d5", bus.SEG, 7'b0000000);
`else
    chk("lz_d5", bus.SEG, 7'b1111110);
`endif
    idle(FRAME_LEN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
